// File: rtl/ddr_tx_sequencer_if.sv
// ddr_tx_sequencer_if: valid/ready word handshake between a word source and the DDR transmit sequencer
interface ddr_tx_sequencer_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/ddr_tx_sequencer.sv
// ddr_tx_sequencer: MSB-first 2-bit/clk serialiser for ddr_out cells with forwarded clock and frame strobe; optional trailing parity pair via DDR_TX_SEQ_PARITY_EN
module ddr_tx_sequencer #(
  parameter int W          = 8,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  ddr_tx_sequencer_if.slave src,
  output logic              out_d_rise,
  output logic              out_d_fall,
  output logic              sck_rise,
  output logic              sck_fall,
  output logic              frame,
  output logic              busy
);
  localparam int CW = $clog2(W / 2) + 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(W / 2 - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  generate
    if (W < 2 || W % 2 != 0) begin : g_bad_w
      $error("ddr_tx_sequencer: W must be even and >= 2");
    end
  endgenerate

`ifdef DDR_TX_SEQ_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [W-1:0]  sreg, sreg_n;
  logic          d_rise_n, d_fall_n, sck_n, frame_n;
  logic          last, take;
`ifdef DDR_TX_SEQ_PARITY_EN
  logic          par, par_n;
`endif

  assign last = state == SHIFT && cnt == '0;
`ifdef DDR_TX_SEQ_PARITY_EN
  assign src.ready = state == IDLE || (state == PARITY && GAP_CYCLES == 0);
`else
  assign src.ready = state == IDLE || (last && GAP_CYCLES == 0);
`endif
  assign take     = src.valid && src.ready;
  assign busy     = state != IDLE;
  assign sck_fall = 1'b0;

  // next state and next registered outputs: load on accept, shift pairs, then parity/gap/idle
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    sreg_n   = sreg;
    d_rise_n = IDLE_LEVEL;
    d_fall_n = IDLE_LEVEL;
    sck_n    = 1'b0;
    frame_n  = 1'b0;
`ifdef DDR_TX_SEQ_PARITY_EN
    par_n    = par;
`endif
    if (take) begin
      state_n              = SHIFT;
      cnt_n                = CNT_LOAD;
      sreg_n               = src.data << 2;
      {d_rise_n, d_fall_n} = src.data[W-1 -: 2];
      sck_n                = 1'b1;
      frame_n              = 1'b1;
`ifdef DDR_TX_SEQ_PARITY_EN
      par_n                = ^src.data;
`endif
    end else if (state == SHIFT && !last) begin
      cnt_n                = cnt - 1'b1;
      sreg_n               = sreg << 2;
      {d_rise_n, d_fall_n} = sreg[W-1 -: 2];
      sck_n                = 1'b1;
      frame_n              = 1'b1;
`ifdef DDR_TX_SEQ_PARITY_EN
    end else if (last) begin
      state_n  = PARITY;
      d_rise_n = par;
      d_fall_n = ~par;
      sck_n    = 1'b1;
      frame_n  = 1'b1;
    end else if (state == PARITY) begin
      state_n = GAP_CYCLES > 0 ? GAP : IDLE;
      gcnt_n  = GAP_LOAD;
`else
    end else if (last) begin
      state_n = GAP_CYCLES > 0 ? GAP : IDLE;
      gcnt_n  = GAP_LOAD;
`endif
    end else if (state == GAP) begin
      state_n = gcnt == '0 ? IDLE : GAP;
      gcnt_n  = gcnt - 1'b1;
    end
  end

  // state and output registers; reset discards any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gcnt       <= '0;
      sreg       <= '0;
      out_d_rise <= IDLE_LEVEL;
      out_d_fall <= IDLE_LEVEL;
      sck_rise   <= 1'b0;
      frame      <= 1'b0;
`ifdef DDR_TX_SEQ_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      gcnt       <= gcnt_n;
      sreg       <= sreg_n;
      out_d_rise <= d_rise_n;
      out_d_fall <= d_fall_n;
      sck_rise   <= sck_n;
      frame      <= frame_n;
`ifdef DDR_TX_SEQ_PARITY_EN
      par        <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// tb_ddr_tx_sequencer: directed checks of a streaming (GAP=0) and a gapped (GAP=2) sequencer
module tb_ddr_tx_sequencer;
  localparam int W = 8;
`ifdef DDR_TX_SEQ_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_tx_sequencer_if #(.W(W)) a_if ();
  ddr_tx_sequencer_if #(.W(W)) b_if ();
  logic a_dr, a_df, a_sr, a_sf, a_fr, a_bz;
  logic b_dr, b_df, b_sr, b_sf, b_fr, b_bz;

  ddr_tx_sequencer #(.W(W), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .src(a_if),
    .out_d_rise(a_dr), .out_d_fall(a_df), .sck_rise(a_sr), .sck_fall(a_sf),
    .frame(a_fr), .busy(a_bz)
  );
  ddr_tx_sequencer #(.W(W), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .src(b_if),
    .out_d_rise(b_dr), .out_d_fall(b_df), .sck_rise(b_sr), .sck_fall(b_sf),
    .frame(b_fr), .busy(b_bz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {in_ready, busy, frame, sck_rise, sck_fall, d_rise, d_fall}
  function automatic logic [6:0] stat(input bit sel);
    return sel ? {b_if.ready, b_bz, b_fr, b_sr, b_sf, b_dr, b_df}
               : {a_if.ready, a_bz, a_fr, a_sr, a_sf, a_dr, a_df};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin b_if.valid = v; b_if.data = d; end
    else begin a_if.valid = v; a_if.data = d; end
  endtask

  // send one or two words with in_valid held high; p0/p1 are the hand-computed parity pairs
  task automatic xfer(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [1:0] p0, input logic [1:0] p1, input bit two, input string tag);
    logic [9:0] e;
    int L = W / 2 + P;
    int nw = two ? 2 : 1;
    check($sformatf("%s_idle0", tag), stat(sel), 7'b1000000);
    drive(sel, 1'b1, w0);
    @(negedge clk);
    for (int wi = 0; wi < nw; wi++) begin
      e = wi == 0 ? {w0, p0} : {w1, p1};
      for (int k = 0; k < L; k++) begin
        check($sformatf("%s_w%0d_k%0d", tag, wi, k), stat(sel),
              {(k == L - 1) && !sel, 4'b1110, e[9-2*k], e[8-2*k]});
        if (wi == 0 && k == 0 && two) drive(sel, 1'b1, w1);
        if (wi == nw - 1 && k == 0) drive(sel, 1'b0, 8'h00);
        @(negedge clk);
      end
      if (sel) begin
        for (int g = 0; g < 2; g++) begin
          check($sformatf("%s_gap%0d_%0d", tag, wi, g), stat(sel), 7'b0100000);
          @(negedge clk);
        end
      end
      if (sel || wi == nw - 1) begin
        check($sformatf("%s_idle%0d", tag, wi + 1), stat(sel), 7'b1000000);
        if (wi < nw - 1) @(negedge clk);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("reset_a", stat(1'b0), 7'b1000000);
    check("reset_b", stat(1'b1), 7'b1000000);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 8'hA5, 8'h00, 2'b01, 2'b01, 1'b0, "a5");
    @(negedge clk);
    xfer(1'b0, 8'h01, 8'h00, 2'b10, 2'b01, 1'b0, "x01");
    @(negedge clk);
    xfer(1'b0, 8'hFF, 8'h00, 2'b01, 2'b01, 1'b1, "ff00");
    @(negedge clk);
    xfer(1'b1, 8'h5A, 8'h81, 2'b01, 2'b01, 1'b1, "gap");
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hC3);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    check("c3_p0", stat(1'b0), 7'b0111011);
    @(negedge clk);
    check("c3_p1", stat(1'b0), 7'b0111000);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", stat(1'b0), 7'b1000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 8'h3C, 8'h00, 2'b01, 2'b01, 1'b0, "x3c");
    repeat (20) @(negedge clk);
    check("quiet_a", stat(1'b0), 7'b1000000);
    check("quiet_b", stat(1'b1), 7'b1000000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
